// File: rtl/reg_op_pkg.sv
// Shared encodings for the register-operation sequencer.
// Opcodes, FSM states and datapath width live here.
package reg_op_pkg;

    localparam int DW = 8;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_NOT = 3'b101,
        OP_LDI = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

endpackage

// File: rtl/reg_op_alu.sv
// Combinational datapath: A is the source operand, B the destination.
// Arithmetic runs in DW+1 bits so bit DW is carry (ADD) or borrow (SUB/CMP).
module reg_op_alu
    import reg_op_pkg::*;
(
    input  op_e           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] imm_i,
    output logic [DW-1:0] result_o,
    output logic          z_o,
    output logic          c_o
);

    logic [DW:0] wide;

    always_comb begin
        wide = '0;
        c_o  = 1'b0;
        unique case (op_i)
            OP_MOV: wide = {1'b0, a_i};
            OP_ADD: begin
                wide = {1'b0, b_i} + {1'b0, a_i};
                c_o  = wide[DW];
            end
            OP_SUB, OP_CMP: begin
                wide = {1'b0, b_i} - {1'b0, a_i};
                c_o  = wide[DW];
            end
            OP_AND: wide = {1'b0, b_i & a_i};
            OP_OR:  wide = {1'b0, b_i | a_i};
            OP_NOT: wide = {1'b0, ~a_i};
            OP_LDI: wide = {1'b0, imm_i};
            default: wide = '0;
        endcase
        result_o = wide[DW-1:0];
        z_o      = (wide[DW-1:0] == '0);
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-state sequencer driving an external register group.
// Every output is registered, so rf_we/rf_i are glitch-free for the falling-edge write.
module reg_op_sequencer
    import reg_op_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [1:0]    cmd_sr,
    input  logic [1:0]    cmd_dr,
    input  logic [DW-1:0] cmd_imm,
    output logic          rf_we,
    output logic [1:0]    rf_sr,
    output logic [1:0]    rf_dr,
    output logic [DW-1:0] rf_i,
    input  logic [DW-1:0] rf_s,
    input  logic [DW-1:0] rf_d,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_c
);

    state_e        state_q;
    op_e           op_q;
    logic [1:0]    sr_q;
    logic [1:0]    dr_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] result_q;
    logic          z_q;
    logic          c_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          done_q;

    logic [DW-1:0] alu_res;
    logic          alu_z;
    logic          alu_c;

    reg_op_alu u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .imm_i    (imm_q),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MOV;
            sr_q     <= '0;
            dr_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        sr_q    <= cmd_sr;
                        dr_q    <= cmd_dr;
                        imm_q   <= cmd_imm;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Both reads happen here, so sr==dr sees the same old value.
                    a_q     <= rf_s;
                    b_q     <= rf_d;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= alu_res;
                    z_q      <= alu_z;
                    c_q      <= alu_c;
                    wdata_q  <= alu_res;
                    we_q     <= (op_q != OP_CMP);
                    done_q   <= 1'b1;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rf_we     = we_q;
    assign rf_sr     = sr_q;
    assign rf_dr     = dr_q;
    assign rf_i      = wdata_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule
